// File: rtl/apb_follower_if.sv
// APB link between a single requester and the apb_follower completer.
interface apb_follower_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_follower.sv
// APB completer: NUM_REGS-1 read/write registers plus a read-only transfer
// counter in the top slot, with a fixed number of wait states per access.
module apb_follower #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          PCLK,
    input  logic          PRESETN,
    apb_follower_if.slave apb
);
    localparam int unsigned WCW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IW      = $clog2(NUM_REGS);
    localparam int unsigned CNT_IDX = NUM_REGS - 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [WCW-1:0]        wait_cnt;
    // Slot CNT_IDX holds the transfer counter; writes to it are decoded as errors.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  ready_c;
    logic                  err_c;
    logic [IW-1:0]         idx_c;

    assign idx_c   = addr_q[IW-1:0];
    assign err_c   = (32'(addr_q) >= NUM_REGS) || (wr_q && (32'(addr_q) == CNT_IDX));
    assign ready_c = (state == ACCESS) && apb.PSEL && apb.PENABLE && (wait_cnt == '0);

    assign apb.PREADY  = ready_c;
    assign apb.PSLVERR = ready_c && err_c;
    assign apb.PRDATA  = (ready_c && !wr_q && !err_c) ? regs[idx_c] : '0;

    // Transfer sequencing, register bank and counter update.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state    <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wait_cnt <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        addr_q   <= apb.PADDR;
                        wr_q     <= apb.PWRITE;
                        wait_cnt <= WCW'(WAIT_CYCLES);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else if (apb.PENABLE) begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - WCW'(1);
                        end else begin
                            if (wr_q && !err_c) begin
                                regs[idx_c] <= apb.PWDATA;
                            end
                            regs[IW'(CNT_IDX)] <= regs[IW'(CNT_IDX)] + DATA_WIDTH'(1);
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
